// File: rtl/mobile_button_events.sv
// Button event peripheral: 2-flop sync, per-bit debounce and change detect into a show-ahead event FIFO.
// Events are pushed on the edge btn_state changes; a push into a full FIFO without a pop is dropped and sets overflow.
module mobile_button_events #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 4,
  parameter int PTR_W           = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       btn_in,
  output logic [7:0]       btn_state,
  output logic             evt_valid,
  output logic [15:0]      evt_data,
  input  logic             evt_pop,
  output logic [PTR_W:0]   evt_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_state;
  logic [CNT_W-1:0] r_cnt [8];
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;

  logic [7:0]       w_state_next;
  logic [CNT_W-1:0] w_cnt_next [8];
  logic [7:0]       w_mask;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr_en;

  // cnt==0 is the STABLE state; any nonzero count means COUNTING
  always_comb begin
    w_state_next = r_state;
    for (int i = 0; i < 8; i++) begin
      w_cnt_next[i] = '0;
      if (r_s2[i] != r_state[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_state_next[i] = ~r_state[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_mask  = w_state_next ^ r_state;
  assign w_push  = |w_mask;
  assign w_pop   = evt_pop && (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_state  <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_s1    <= btn_in;
      r_s2    <= r_s1;
      r_state <= w_state_next;
      for (int i = 0; i < 8; i++) r_cnt[i] <= w_cnt_next[i];
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (ovf_clr)               r_ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the count gates everything read out of it
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {w_mask, w_state_next};
  end

  assign btn_state = r_state;
  assign evt_valid = (r_count != '0);
  assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign evt_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_mobile_button_events.sv
// Directed bench for mobile_button_events with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Expected events go into a scoreboard queue as stimulus is applied and are compared as they are popped.
module tb_mobile_button_events;

  logic        clk;
  logic        reset;
  logic [7:0]  btn_in;
  logic [7:0]  btn_state;
  logic        evt_valid;
  logic [15:0] evt_data;
  logic        evt_pop;
  logic [2:0]  evt_count;
  logic        overflow;
  logic        ovf_clr;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb [$];
  logic [7:0]  model_state;

  mobile_button_events #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .FIFO_DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_data(evt_data),
    .evt_pop(evt_pop),
    .evt_count(evt_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e_dat;
    e_dat = 16'h0000;
    if (sb.size() != 0) e_dat = sb.pop_front();
    check({tag, "_vld"}, 32'(evt_valid), 32'd1);
    check(tag, 32'(evt_data), 32'(e_dat));
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
  endtask

  // Drive a new level, record the event the model predicts, and let it settle
  task automatic apply(input logic [7:0] p, input bit expect_push);
    btn_in = p;
    if (expect_push) sb.push_back({p ^ model_state, p});
    model_state = p;
    repeat (8) tick();
  endtask

  initial begin
    reset       = 1'b1;
    btn_in      = 8'hFF;
    evt_pop     = 1'b0;
    ovf_clr     = 1'b0;
    model_state = 8'h00;

    // Reset held with all buttons pressed
    repeat (3) tick();
    check("rst_state", 32'(btn_state), 32'h00);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_data",  32'(evt_data),  32'h0000);
    reset = 1'b0;
    repeat (5) tick();
    check("rel_state_e5", 32'(btn_state), 32'h00);
    sb.push_back(16'hFFFF);
    model_state = 8'hFF;
    tick();
    check("rel_state_e6", 32'(btn_state), 32'hFF);
    check("rel_count", 32'(evt_count), 32'd1);
    pop_check("rel_evt");
    check("rel_count_after", 32'(evt_count), 32'd0);

    // Single-bit rise with exact latency
    btn_in = 8'h00;
    reset  = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_state = 8'h00;
    btn_in = 8'h01;
    repeat (5) tick();
    check("b0_state_e5", 32'(btn_state), 32'h00);
    sb.push_back(16'h0101);
    model_state = 8'h01;
    tick();
    check("b0_state_e6", 32'(btn_state), 32'h01);
    check("b0_count", 32'(evt_count), 32'd1);
    pop_check("b0_evt");
    check("b0_valid_after", 32'(evt_valid), 32'd0);
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    check("empty_pop_count", 32'(evt_count), 32'd0);
    check("empty_data", 32'(evt_data), 32'h0000);

    // Glitch shorter than the debounce window
    btn_in = 8'h09;
    repeat (3) tick();
    btn_in = 8'h01;
    repeat (8) tick();
    check("glitch_state", 32'(btn_state), 32'h01);
    check("glitch_count", 32'(evt_count), 32'd0);

    // Falling edge, then two bits settling together
    apply(8'h00, 1'b1);
    pop_check("fall_evt");
    apply(8'h22, 1'b1);
    check("dual_count", 32'(evt_count), 32'd1);
    pop_check("dual_evt");

    // Overflow: five changes, fifth dropped
    apply(8'h23, 1'b1);
    apply(8'h27, 1'b1);
    apply(8'h2F, 1'b1);
    apply(8'h3F, 1'b1);
    check("full_count", 32'(evt_count), 32'd4);
    check("full_ovf0", 32'(overflow), 32'd0);
    apply(8'h7F, 1'b0);
    check("ovf_count", 32'(evt_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_state", 32'(btn_state), 32'h7F);
    repeat (4) pop_check("ovf_drain");
    check("ovf_drained", 32'(evt_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with pop coinciding with a new push
    apply(8'hFF, 1'b1);
    apply(8'hFE, 1'b1);
    apply(8'hFC, 1'b1);
    apply(8'hF8, 1'b1);
    check("full2_count", 32'(evt_count), 32'd4);
    btn_in = 8'hF0;
    sb.push_back(16'h08F0);
    model_state = 8'hF0;
    repeat (5) tick();
    check("pp_state_before", 32'(btn_state), 32'hF8);
    check("pp_head", 32'(evt_data), 32'(sb.pop_front()));
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    check("pp_state", 32'(btn_state), 32'hF0);
    check("pp_count", 32'(evt_count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);
    repeat (4) pop_check("pp_drain");
    check("pp_drained", 32'(evt_count), 32'd0);

    // Reset in the middle of a debounce run
    btn_in = 8'hF1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    model_state = 8'h00;
    check("mid_rst_state", 32'(btn_state), 32'h00);
    check("mid_rst_count", 32'(evt_count), 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    repeat (5) tick();
    check("mid_rst_state_e5", 32'(btn_state), 32'h00);
    check("mid_rst_count_e5", 32'(evt_count), 32'd0);
    sb.push_back(16'hF1F1);
    model_state = 8'hF1;
    tick();
    check("mid_rst_state_e6", 32'(btn_state), 32'hF1);
    pop_check("mid_rst_evt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
